// File: rtl/ddr_local_pkg.sv
// Shared types for the DDR local-port master.
// Default widths, FSM state encoding and the tag-FIFO entry.
package ddr_local_pkg;

  localparam int DEF_ADDR_W = 26;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_TAG_W  = 4;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_RDWAIT,
    S_READ
  } state_t;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [2:0]           size;
  } tag_ent_t;

endpackage

// File: rtl/ddr_local_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Ports: clock/reset, push/din, pop/dout, count.
module ddr_local_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ddr_local_master.sv
// Local-port initiator: request/wdata streams to local_* bursts.
// Ports: req_*, wdat_*, resp_*, wack_*, err, local_* controller side.
module ddr_local_master
  import ddr_local_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int MAX_BURST = 4,
  parameter int RD_DEPTH  = 16,
  parameter int OUTSTD    = 4,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [DATA_W-1:0] wdat_data,
  input  logic [BE_W-1:0]   wdat_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_last,
  output logic              wack_valid,
  output logic [TAG_W-1:0]  wack_tag,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] local_address,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic              local_burstbegin,
  output logic [DATA_W-1:0] local_wdata,
  output logic [BE_W-1:0]   local_be,
  output logic [2:0]        local_size,
  input  logic              local_ready,
  input  logic              local_rdata_valid,
  input  logic              local_init_done,
  input  logic [DATA_W-1:0] local_rdata
);

  localparam int CW  = $clog2(RD_DEPTH) + 1;
  localparam int TCW = $clog2(OUTSTD) + 1;
  localparam int RW  = DATA_W + TAG_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [TAG_W-1:0]  tag_q;
  logic [2:0]        wbeat;
  logic [2:0]        rbeat;
  logic [CW-1:0]     credits;
  logic              err_size;
  logic              err_orphan;

  tag_ent_t          tf_din;
  tag_ent_t          tf_dout;
  logic              tf_push;
  logic              tf_pop;
  logic [TCW-1:0]    tf_count;
  logic              tf_empty;
  logic              tf_full;

  logic [RW-1:0]     rf_din;
  logic [RW-1:0]     rf_dout;
  logic              rf_push;
  logic              rf_pop;
  logic [CW-1:0]     rf_count;

  logic size_ok;
  logic wr_acc;
  logic reserve;
  logic rd_last;

  assign size_ok = (req_size != 3'd0) &&
                   (req_size <= 3'(MAX_BURST));
  assign wr_acc  = (state == S_WRITE) &&
                   wdat_valid && local_ready;
  assign reserve = (state == S_RDWAIT) &&
                   (credits >= CW'(size_q)) &&
                   !tf_full;
  assign req_ready = state == S_IDLE;
  assign err       = {err_orphan, err_size};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      addr_q     <= '0;
      size_q     <= '0;
      tag_q      <= '0;
      wbeat      <= '0;
      wack_valid <= 1'b0;
      wack_tag   <= '0;
      err_size   <= 1'b0;
    end else begin
      wack_valid <= 1'b0;
      unique case (state)
        S_INIT: if (local_init_done) state <= S_IDLE;
        S_IDLE: if (req_valid) begin
          addr_q <= req_addr;
          size_q <= size_ok ? req_size : 3'd1;
          tag_q  <= req_tag;
          wbeat  <= '0;
          if (!size_ok) err_size <= 1'b1;
          state  <= req_write ? S_WRITE : S_RDWAIT;
        end
        S_WRITE: if (wr_acc) begin
          if (wbeat == size_q - 3'd1) begin
            wack_valid <= 1'b1;
            wack_tag   <= tag_q;
            state      <= S_IDLE;
          end else begin
            wbeat <= wbeat + 3'd1;
          end
        end
        S_RDWAIT: if (reserve) state <= S_READ;
        S_READ: if (local_ready) state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    local_address    = '0;
    local_size       = '0;
    local_write_req  = 1'b0;
    local_read_req   = 1'b0;
    local_burstbegin = 1'b0;
    local_wdata      = '0;
    local_be         = '0;
    wdat_ready       = 1'b0;
    unique case (state)
      S_WRITE: begin
        local_address    = addr_q;
        local_size       = size_q;
        local_write_req  = wdat_valid;
        local_wdata      = wdat_data;
        local_be         = wdat_be;
        wdat_ready       = local_ready;
        local_burstbegin = wdat_valid &&
                           (wbeat == 3'd0);
      end
      S_READ: begin
        local_address    = addr_q;
        local_size       = size_q;
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
      end
      default: ;
    endcase
  end

  // Credits count free response slots not yet promised to a burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) credits <= CW'(RD_DEPTH);
    else credits <= credits
                  - (reserve ? CW'(size_q) : '0)
                  + CW'(rf_pop);
  end

  assign tf_empty = tf_count == '0;
  assign tf_full  = tf_count == TCW'(OUTSTD);
  assign tf_din   = '{tag: tag_q, size: size_q};
  assign tf_push  = (state == S_READ) && local_ready;
  assign rd_last  = (rbeat + 3'd1) == tf_dout.size;
  assign tf_pop   = local_rdata_valid && !tf_empty &&
                    rd_last;
  assign rf_push  = local_rdata_valid && !tf_empty;
  assign rf_din   = {local_rdata, tf_dout.tag, rd_last};
  assign rf_pop   = resp_valid && resp_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rbeat      <= '0;
      err_orphan <= 1'b0;
    end else if (local_rdata_valid) begin
      if (tf_empty)     err_orphan <= 1'b1;
      else if (rd_last) rbeat <= '0;
      else              rbeat <= rbeat + 3'd1;
    end
  end

  ddr_local_fifo #(
    .WIDTH ($bits(tag_ent_t)),
    .DEPTH (OUTSTD)
  ) u_tag_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tf_push),
    .din   (tf_din),
    .pop   (tf_pop),
    .dout  (tf_dout),
    .count (tf_count)
  );

  ddr_local_fifo #(
    .WIDTH (RW),
    .DEPTH (RD_DEPTH)
  ) u_resp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rf_push),
    .din   (rf_din),
    .pop   (rf_pop),
    .dout  (rf_dout),
    .count (rf_count)
  );

  assign resp_valid = rf_count != '0;
  assign resp_data  = resp_valid ?
                      rf_dout[RW-1 -: DATA_W] : '0;
  assign resp_tag   = resp_valid ?
                      rf_dout[TAG_W:1] : '0;
  assign resp_last  = resp_valid && rf_dout[0];

endmodule
